// File: rtl/game_pkg.sv
// Shared types, default constants and helpers for the game-rules engine.
// Coordinates are widened to ABS_W bits before subtraction so |a-b| never wraps.
package game_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Signed working width for distances; holds COORD_W+1 for COORD_W <= 16.
    localparam int ABS_W = 17;

    localparam int DEF_ATTACK_RANGE  = 48;
    localparam int DEF_CONTACT_RANGE = 32;
    localparam int DEF_INVULN_FRAMES = 120;

    // Absolute difference of two zero-extended coordinates.
    function automatic logic [ABS_W-1:0] abs_diff(
        input logic [ABS_W-1:0] a,
        input logic [ABS_W-1:0] b
    );
        logic [ABS_W-1:0] d;
        d = a - b;
        return d[ABS_W-1] ? ({ABS_W{1'b0}} - d) : d;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD accumulator with a ripple carry between digits.
// Adds a 0..9 increment per enable; wraps modulo 10^DIGITS.
module bcd_score_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  bcd_digit_t          inc_i,
    output logic [4*DIGITS-1:0] score_o
);

    logic [4*DIGITS-1:0] score_q;
    logic [4*DIGITS-1:0] score_d;
    logic [4:0]          carry;
    logic [4:0]          sum;

    // Ripple the increment through the digits, carrying at most 1 past digit 0.
    always_comb begin
        score_d = '0;
        carry   = {1'b0, inc_i};
        sum     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sum = {1'b0, score_q[4*i +: 4]} + carry;
            if (sum >= 5'd10) begin
                score_d[4*i +: 4] = 4'(sum - 5'd10);
                carry             = 5'd1;
            end else begin
                score_d[4*i +: 4] = sum[3:0];
                carry             = 5'd0;
            end
        end
    end

    // Score register: clear has priority over accumulate.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            score_q <= '0;
        end else if (en_i) begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Per-frame rules engine: attack hits, contact damage, health, BCD score,
// invulnerability window and a restartable PLAY/OVER state machine.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES   = 5,
    parameter int COORD_W       = 10,
    parameter int ATTACK_RANGE  = DEF_ATTACK_RANGE,
    parameter int CONTACT_RANGE = DEF_CONTACT_RANGE,
    parameter int MAX_HEALTH    = 3,
    parameter int HEALTH_W      = 2,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int SCORE_DIGITS  = 2
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Frame_tick,
    input  logic                           Player_Attack,
    input  logic                           Restart,
    input  logic [COORD_W-1:0]             Player_X,
    input  logic [COORD_W-1:0]             Player_Y,
    input  logic [NUM_ENEMIES*COORD_W-1:0] Enemy_X,
    input  logic [NUM_ENEMIES*COORD_W-1:0] Enemy_Y,
    input  logic [NUM_ENEMIES-1:0]         Enemy_Alive,
    output logic [NUM_ENEMIES-1:0]         Damage_E,
    output logic [4*SCORE_DIGITS-1:0]      score,
    output logic [HEALTH_W-1:0]            health,
    output logic                           invuln,
    output logic                           game_over
);

    localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    game_state_t          state_q, state_d;
    logic                 attack_prev_q;
    logic [HEALTH_W-1:0]  health_q, health_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_ENEMIES-1:0] damage_q;

    logic [NUM_ENEMIES-1:0] in_att;
    logic [NUM_ENEMIES-1:0] in_con;
    logic [NUM_ENEMIES-1:0] hit;
    logic                   tick_play;
    logic                   attack_edge;
    logic                   contact;
    logic                   take_hit;
    logic                   restart_go;
    bcd_digit_t             hit_cnt;
    logic [ABS_W-1:0]       dx, dy;

    assign tick_play   = Frame_tick && (state_q == PLAY);
    assign attack_edge = Player_Attack && !attack_prev_q;
    assign restart_go  = Frame_tick && (state_q == OVER) && Restart;

    // Per-enemy range tests, hit vector, contact and hit count.
    always_comb begin
        in_att  = '0;
        in_con  = '0;
        hit     = '0;
        hit_cnt = '0;
        dx      = '0;
        dy      = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            dx = abs_diff(ABS_W'(Player_X), ABS_W'(Enemy_X[i*COORD_W +: COORD_W]));
            dy = abs_diff(ABS_W'(Player_Y), ABS_W'(Enemy_Y[i*COORD_W +: COORD_W]));
            in_att[i] = (dx < ABS_W'(ATTACK_RANGE)) && (dy < ABS_W'(ATTACK_RANGE));
            in_con[i] = (dx < ABS_W'(CONTACT_RANGE)) && (dy < ABS_W'(CONTACT_RANGE));
        end
        if (tick_play && attack_edge) begin
            hit = Enemy_Alive & in_att;
        end
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            hit_cnt = hit_cnt + bcd_digit_t'(hit[i]);
        end
    end

    // An enemy struck this frame cannot also deal contact damage.
    assign contact  = |(Enemy_Alive & ~hit & in_con);
    assign take_hit = tick_play && contact && (cnt_q == '0);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLAY: if (take_hit && (health_q == HEALTH_W'(1))) state_d = OVER;
            OVER: if (restart_go) state_d = PLAY;
            default: state_d = PLAY;
        endcase
    end

    // Health and invulnerability next values.
    always_comb begin
        health_d = health_q;
        cnt_d    = cnt_q;
        if (restart_go) begin
            health_d = HEALTH_W'(MAX_HEALTH);
            cnt_d    = CNT_W'(INVULN_FRAMES);
        end else if (take_hit) begin
            health_d = health_q - HEALTH_W'(1);
            cnt_d    = CNT_W'(INVULN_FRAMES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Frame-gated datapath registers; damage pulse lasts one Clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            attack_prev_q <= 1'b0;
            health_q      <= HEALTH_W'(MAX_HEALTH);
            cnt_q         <= '0;
            damage_q      <= '0;
        end else begin
            damage_q <= hit;
            if (Frame_tick) begin
                attack_prev_q <= Player_Attack;
                health_q      <= health_d;
                cnt_q         <= cnt_d;
            end
        end
    end

    bcd_score_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (restart_go),
        .en_i    (tick_play),
        .inc_i   (hit_cnt),
        .score_o (score)
    );

    // Output decode.
    always_comb begin
        Damage_E  = damage_q;
        health    = health_q;
        invuln    = (cnt_q != '0);
        game_over = (state_q == OVER);
    end

endmodule
